pe: RTL and testbench

- Convolution processing element: multiply-accumulate over one K×K kernel window.
- Streams one signed pixel and one signed weight per clock, with no input handshake.
- After K*K consecutive samples, presents the signed dot product on result and pulses valid for one cycle.
- Instantiated inside the CNN convolution array, one PE per output feature-map pixel computation.

---
 rtl/pe.sv | 61 ++++++
 tb/tb_pe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pe.sv
// Convolution processing element: streams pixel/weight pairs, multiply-accumulates
// over one KERNEL_SIZE x KERNEL_SIZE window and pulses valid with the dot product.
module pe #(
    parameter int unsigned KERNEL_SIZE  = 5,
    parameter int unsigned PIC_WIDTH    = 16,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned RESULT_WIDTH = 37
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [PIC_WIDTH-1:0]    picDat,
    input  logic signed [WEIGHT_WIDTH-1:0] weightDat,
    output logic signed [RESULT_WIDTH-1:0] result,
    output logic                           valid
);

    localparam int unsigned N      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PROD_W = PIC_WIDTH + WEIGHT_WIDTH;

    logic        [CNT_W-1:0]        cnt;
    logic signed [PROD_W-1:0]       prod_reg;
    logic                           last_reg;
    logic                           pvld_reg;
    logic signed [RESULT_WIDTH-1:0] acc;
    logic signed [RESULT_WIDTH-1:0] sum;
    logic                           cnt_last;

    assign cnt_last = (cnt == CNT_W'(N - 1));
    assign sum      = acc + RESULT_WIDTH'(prod_reg);

    // Stage 1 registers the product, stage 2 folds it into the accumulator.
    // rst_n is high-true: a high level at the edge clears the whole pipeline.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt      <= '0;
            prod_reg <= '0;
            last_reg <= 1'b0;
            pvld_reg <= 1'b0;
            acc      <= '0;
            result   <= '0;
            valid    <= 1'b0;
        end else begin
            prod_reg <= PROD_W'(picDat) * PROD_W'(weightDat);
            last_reg <= cnt_last;
            pvld_reg <= 1'b1;
            cnt      <= cnt_last ? '0 : cnt + CNT_W'(1);
            valid    <= 1'b0;
            if (pvld_reg) begin
                if (last_reg) begin
                    result <= sum;
                    valid  <= 1'b1;
                    acc    <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: directed window table, multi-cycle sequences and
// randomized stimulus against a window-sum reference model.
module tb_pe;

    localparam int unsigned K  = 5;
    localparam int unsigned PW = 16;
    localparam int unsigned WW = 16;
    localparam int unsigned RW = 37;
    localparam int          N  = K * K;

    logic                 clk;
    logic                 rst_n;
    logic signed [PW-1:0] picDat;
    logic signed [WW-1:0] weightDat;
    logic signed [RW-1:0] result;
    logic                 valid;

    int vectors;
    int miscompares;

    // reference model state: running window
    longint win_sum;
    int     win_cnt;
    bit     pend;
    longint pend_sum;
    bit     m_valid;
    longint m_result;

    typedef struct {
        int     pic_a;
        int     wt_a;
        int     n_a;
        int     pic_b;
        int     wt_b;
        int     n_b;
        longint exp_result;
    } win_vec_t;

    win_vec_t vecs[5];

    pe #(
        .KERNEL_SIZE (K),
        .PIC_WIDTH   (PW),
        .WEIGHT_WIDTH(WW),
        .RESULT_WIDTH(RW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .picDat   (picDat),
        .weightDat(weightDat),
        .result   (result),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: a reset empties the window; a full window yields its sum one edge later.
    task automatic model_edge(input bit r, input int p, input int w);
        if (r) begin
            win_sum  = 0;
            win_cnt  = 0;
            pend     = 0;
            m_valid  = 0;
            m_result = 0;
        end else begin
            m_valid = pend;
            if (pend) m_result = pend_sum;
            pend = 0;
            win_sum += longint'(p) * longint'(w);
            win_cnt++;
            if (win_cnt == N) begin
                pend     = 1;
                pend_sum = win_sum;
                win_sum  = 0;
                win_cnt  = 0;
            end
        end
    endtask

    task automatic step(input bit r, input int p, input int w);
        rst_n     = r;
        picDat    = PW'(p);
        weightDat = WW'(w);
        @(posedge clk);
        #1;
        model_edge(r, p, w);
        chk("valid", longint'(valid), longint'(m_valid));
        chk("result", longint'(result), m_result);
    endtask

    int pulses;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        picDat      = '0;
        weightDat   = '0;
        model_edge(1, 0, 0);

        vecs[0] = '{2, 2, 25, 0, 0, 0, 100};
        vecs[1] = '{1, 1, 24, -2, -2, 1, 28};
        vecs[2] = '{2, 2, 12, 1, -1, 13, 35};
        vecs[3] = '{-32768, -32768, 25, 0, 0, 0, 64'sd26843545600};
        vecs[4] = '{-32768, 32767, 25, 0, 0, 0, -64'sd26842726400};

        // reset state
        step(1, 0, 0);
        chk("reset_valid", longint'(valid), 0);
        chk("reset_result", longint'(result), 0);

        // directed windows from the table
        foreach (vecs[i]) begin
            step(1, 0, 0);
            for (int j = 0; j < vecs[i].n_a; j++) step(0, vecs[i].pic_a, vecs[i].wt_a);
            for (int j = 0; j < vecs[i].n_b; j++) step(0, vecs[i].pic_b, vecs[i].wt_b);
            chk("pre_pulse_valid", longint'(valid), 0);
            step(0, 0, 0);
            chk("win_valid", longint'(valid), 1);
            chk("win_result", longint'(result), vecs[i].exp_result);
            for (int j = 0; j < 5; j++) step(0, 0, 0);
            chk("hold_valid", longint'(valid), 0);
            chk("hold_result", longint'(result), vecs[i].exp_result);
        end

        // continuous back-to-back windows
        step(1, 0, 0);
        pulses = 0;
        for (int j = 0; j < 251; j++) begin
            step(0, 1, 1);
            if (valid) pulses++;
        end
        chk("pulse_count", longint'(pulses), 10);

        // mid-window reset discards the partial sum
        step(1, 0, 0);
        for (int j = 0; j < 10; j++) step(0, 3, 3);
        step(1, 0, 0);
        chk("midrst_valid", longint'(valid), 0);
        chk("midrst_result", longint'(result), 0);
        for (int j = 0; j < 25; j++) step(0, 1, 1);
        step(0, 0, 0);
        chk("after_midrst_valid", longint'(valid), 1);
        chk("after_midrst_result", longint'(result), 25);

        // long reset, counting starts at the first edge after release
        for (int j = 0; j < 8; j++) step(1, 7, 7);
        chk("long_rst_result", longint'(result), 0);
        for (int j = 0; j < 25; j++) step(0, 1, 1);
        step(0, 0, 0);
        chk("long_rst_valid", longint'(valid), 1);
        chk("long_rst_result2", longint'(result), 25);

        // randomized traffic with occasional resets
        step(1, 0, 0);
        for (int j = 0; j < 600; j++) begin
            int p;
            int w;
            bit r;
            p = int'($urandom_range(0, 65535)) - 32768;
            w = int'($urandom_range(0, 65535)) - 32768;
            r = ($urandom_range(0, 99) == 0);
            step(r, p, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
